pipe_id_fetch_ctrl: RTL

//  ID-side partner of the pipelined IF stage. Registers IF outputs (inst/pc/p4) in the IF/ID latch,

---
 rtl/pipe_id_fetch_ctrl_pkg.sv | 44 ++++
 rtl/pipe_ifid_reg.sv | 30 +++
 rtl/pipe_id_fetch_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/pipe_id_fetch_ctrl_pkg.sv
// ISA constants and a small decoder shared by the ID-side fetch control block.
// Fields: op=[31:26] rs=[25:21] rt=[20:16] imm=[15:0] addr=[25:0] funct=[5:0].
package pipe_id_fetch_ctrl_pkg;

    localparam logic [5:0]  OP_RTYPE = 6'b000000;
    localparam logic [5:0]  OP_J     = 6'b000010;
    localparam logic [5:0]  OP_JAL   = 6'b000011;
    localparam logic [5:0]  OP_BEQ   = 6'b000100;
    localparam logic [5:0]  OP_BNE   = 6'b000101;
    localparam logic [5:0]  OP_LUI   = 6'b001111;
    localparam logic [5:0]  FUNCT_JR = 6'b001000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef struct packed {
        logic is_j;
        logic is_jal;
        logic is_jr;
        logic is_beq;
        logic is_bne;
        logic use_rs;
        logic use_rt;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] i);
        dec_t d;
        logic [5:0] op;
        logic       rtype, i_alu, load, store;
        op       = i[31:26];
        rtype    = (op == OP_RTYPE);
        // lui carries no source register, so it is excluded from the ALU-immediate group
        i_alu    = (op[5:3] == 3'b001) && (op != OP_LUI);
        load     = (op[5:3] == 3'b100);
        store    = (op[5:3] == 3'b101);
        d.is_j   = (op == OP_J);
        d.is_jal = (op == OP_JAL);
        d.is_jr  = rtype && (i[5:0] == FUNCT_JR);
        d.is_beq = (op == OP_BEQ);
        d.is_bne = (op == OP_BNE);
        d.use_rs = rtype | i_alu | load | store | d.is_beq | d.is_bne;
        d.use_rt = rtype | store | d.is_beq | d.is_bne;
        return d;
    endfunction

endpackage

// File: rtl/pipe_ifid_reg.sv
// IF/ID pipeline latch: inst/pc/p4 with async clear, load enable and a flush
// that turns the captured instruction into a NOP while still taking pc/p4.
module pipe_ifid_reg
    import pipe_id_fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    input  logic [31:0] p4,
    output logic [31:0] d_inst,
    output logic [31:0] d_pc,
    output logic [31:0] d_p4
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            d_inst <= NOP;
            d_pc   <= '0;
            d_p4   <= '0;
        end else if (en) begin
            d_inst <= flush ? NOP : inst;
            d_pc   <= pc;
            d_p4   <= p4;
        end
    end

endmodule

// File: rtl/pipe_id_fetch_ctrl.sv
// ID-stage control partner of the pipelined fetch stage: resolves jumps and
// branches, computes the redirect target and raises load-use / branch-operand interlocks.
module pipe_id_fetch_ctrl
    import pipe_id_fetch_ctrl_pkg::*;
#(
    parameter bit DELAY_SLOT = 1'b0
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    input  logic [31:0] p4,
    input  logic [31:0] qa,
    input  logic [31:0] qb,
    input  logic        ex_wreg,
    input  logic        ex_m2reg,
    input  logic [4:0]  ex_rn,
    input  logic        mem_wreg,
    input  logic        mem_m2reg,
    input  logic [4:0]  mem_rn,
    output logic        IFwip,
    output logic        will_jump,
    output logic [31:0] jump_pc,
    output logic [31:0] d_inst,
    output logic [31:0] d_pc,
    output logic [31:0] d_p4,
    output logic        id_bubble
);

    dec_t        dec;
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    logic [31:0] br_off;
    logic        is_br, taken, stall;
    logic        ex_hit, mem_hit, load_use, br_hazard;

    assign dec    = decode(d_inst);
    assign rs     = d_inst[25:21];
    assign rt     = d_inst[20:16];
    assign imm    = d_inst[15:0];
    assign br_off = {{14{imm[15]}}, imm, 2'b00};
    assign is_br  = dec.is_beq | dec.is_bne | dec.is_jr;

    assign taken = dec.is_j | dec.is_jal | dec.is_jr
                 | (dec.is_beq & (qa == qb))
                 | (dec.is_bne & (qa != qb));

    always_comb begin
        jump_pc = '0;
        if (dec.is_beq | dec.is_bne)
            jump_pc = d_p4 + br_off;
        else if (dec.is_j | dec.is_jal)
            jump_pc = {d_p4[31:28], d_inst[25:0], 2'b00};
        else if (dec.is_jr)
            jump_pc = qa;
    end

    // Register 0 is hard-wired, so a zero destination never blocks anything
    assign ex_hit  = (ex_rn != 5'd0)
                   & ((dec.use_rs & (rs == ex_rn)) | (dec.use_rt & (rt == ex_rn)));
    assign mem_hit = (mem_rn != 5'd0)
                   & ((dec.use_rs & (rs == mem_rn)) | (dec.use_rt & (rt == mem_rn)));

    assign load_use  = ex_wreg & ex_m2reg & ex_hit;
    // Compares in ID cannot see an EX result or a MEM load value through the forwarding muxes
    assign br_hazard = is_br & ((ex_wreg & ex_hit) | (mem_wreg & mem_m2reg & mem_hit));
    assign stall     = load_use | br_hazard;

    assign IFwip     = ~stall;
    assign id_bubble = stall;
    assign will_jump = taken & ~stall;

    pipe_ifid_reg u_ifid (
        .clk    (clk),
        .clr    (clr),
        .en     (~stall),
        .flush  (will_jump & ~DELAY_SLOT),
        .inst   (inst),
        .pc     (pc),
        .p4     (p4),
        .d_inst (d_inst),
        .d_pc   (d_pc),
        .d_p4   (d_p4)
    );

endmodule
